// File: rtl/rdm_sched_pkg.sv
// Shared types and defaults for the RDM user scheduler.
// Holds the FSM state encoding, error codes and default widths.
package rdm_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_REQ,
        S_GAP
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_WDT  = 2'd1;
    localparam logic [1:0] ERR_CNT  = 2'd2;

    localparam int NUM_USERS_D = 8;
    localparam int E01_W_D     = 14;
    localparam int NCB_W_D     = 16;
    localparam int QM_W_D      = 4;
    localparam int GAP_D       = 2;
    localparam int WDT_W_D     = 20;

endpackage

// File: rtl/rdm_user_scheduler_if.sv
// Scheduler <-> RDM combine engine request/done bundle.
// The scheduler is master; the combine engine is slave.
interface rdm_user_scheduler_if
    import rdm_sched_pkg::*;
#(
    parameter int E01_W = E01_W_D,
    parameter int NCB_W = NCB_W_D,
    parameter int QM_W  = QM_W_D
) ();

    logic             o_Combine_process_request;
    logic [3:0]       o_Combine_user_index;
    logic [E01_W-1:0] o_Current_Combine_E01_Size;
    logic [NCB_W-1:0] o_Current_Combine_Ncb_Size;
    logic [QM_W-1:0]  o_users_qm;
    logic             i_combine_done;

    modport master (
        output o_Combine_process_request,
        output o_Combine_user_index,
        output o_Current_Combine_E01_Size,
        output o_Current_Combine_Ncb_Size,
        output o_users_qm,
        input  i_combine_done
    );

    modport slave (
        input  o_Combine_process_request,
        input  o_Combine_user_index,
        input  o_Current_Combine_E01_Size,
        input  o_Current_Combine_Ncb_Size,
        input  o_users_qm,
        output i_combine_done
    );

endinterface

// File: rtl/rdm_user_cfg_table.sv
// Per-user configuration register file: one write port,
// combinational read port, synchronous clear.
module rdm_user_cfg_table
    import rdm_sched_pkg::*;
#(
    parameter int NUM_USERS = NUM_USERS_D,
    parameter int E01_W     = E01_W_D,
    parameter int NCB_W     = NCB_W_D,
    parameter int QM_W      = QM_W_D,
    parameter int AW        = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [3:0]       waddr_i,
    input  logic [E01_W-1:0] e01_i,
    input  logic [NCB_W-1:0] ncb_i,
    input  logic [QM_W-1:0]  qm_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [E01_W-1:0] e01_o,
    output logic [NCB_W-1:0] ncb_o,
    output logic [QM_W-1:0]  qm_o
);

    localparam logic [4:0] NU5 = 5'(NUM_USERS);

    logic [E01_W-1:0] e01_q [NUM_USERS];
    logic [NCB_W-1:0] ncb_q [NUM_USERS];
    logic [QM_W-1:0]  qm_q  [NUM_USERS];

    logic wr_ok;
    assign wr_ok = we_i && ({1'b0, waddr_i} < NU5);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_USERS; i++) begin
                e01_q[i] <= '0;
                ncb_q[i] <= '0;
                qm_q[i]  <= '0;
            end
        end else if (wr_ok) begin
            e01_q[waddr_i[AW-1:0]] <= e01_i;
            ncb_q[waddr_i[AW-1:0]] <= ncb_i;
            qm_q[waddr_i[AW-1:0]]  <= qm_i;
        end
    end

    // Reads see the pre-write value in a write cycle.
    assign e01_o = e01_q[raddr_i];
    assign ncb_o = ncb_q[raddr_i];
    assign qm_o  = qm_q[raddr_i];

endmodule

// File: rtl/rdm_user_scheduler.sv
// Sequences the RDM combine engine across the users of a slot,
// with inter-user gap, skip on E01=0, watchdog and abort.
module rdm_user_scheduler
    import rdm_sched_pkg::*;
#(
    parameter int NUM_USERS  = NUM_USERS_D,
    parameter int E01_W      = E01_W_D,
    parameter int NCB_W      = NCB_W_D,
    parameter int QM_W       = QM_W_D,
    parameter int GAP_CYCLES = GAP_D,
    parameter int WDT_W      = WDT_W_D
) (
    input  logic               i_core_clk,
    input  logic               i_rx_rst,
    input  logic               i_cfg_we,
    input  logic [3:0]         i_cfg_user,
    input  logic [E01_W-1:0]   i_cfg_e01,
    input  logic [NCB_W-1:0]   i_cfg_ncb,
    input  logic [QM_W-1:0]    i_cfg_qm,
    input  logic [3:0]         i_num_users,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [WDT_W-1:0]   i_wdt_limit,
    rdm_user_scheduler_if.master eng,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err,
    output logic [1:0]         o_err_code,
    output logic [3:0]         o_err_user
);

    localparam int AW = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1;
    localparam logic [4:0] NU5    = 5'(NUM_USERS);
    localparam logic [3:0] GAP_M1 = 4'(GAP_CYCLES - 1);

    state_e           state_q, state_d;
    logic [3:0]       user_q, user_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       gap_q, gap_d;
    logic [WDT_W-1:0] wdt_q, wdt_d;
    logic [3:0]       idx_q, idx_d;
    logic [E01_W-1:0] e01_q, e01_d;
    logic [NCB_W-1:0] ncb_q, ncb_d;
    logic [QM_W-1:0]  qm_q, qm_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [1:0]       code_q, code_d;
    logic [3:0]       euser_q, euser_d;

    logic [E01_W-1:0] rd_e01;
    logic [NCB_W-1:0] rd_ncb;
    logic [QM_W-1:0]  rd_qm;
    logic             adv;
    logic             wdt_hit;

    rdm_user_cfg_table #(
        .NUM_USERS (NUM_USERS),
        .E01_W     (E01_W),
        .NCB_W     (NCB_W),
        .QM_W      (QM_W),
        .AW        (AW)
    ) u_tbl (
        .clk_i   (i_core_clk),
        .rst_i   (i_rx_rst),
        .we_i    (i_cfg_we),
        .waddr_i (i_cfg_user),
        .e01_i   (i_cfg_e01),
        .ncb_i   (i_cfg_ncb),
        .qm_i    (i_cfg_qm),
        .raddr_i (user_q[AW-1:0]),
        .e01_o   (rd_e01),
        .ncb_o   (rd_ncb),
        .qm_o    (rd_qm)
    );

    // Expiry is flagged one count early so o_err lands L cycles after the request rises.
    assign wdt_hit = (i_wdt_limit != '0) &&
                     (wdt_q == i_wdt_limit - WDT_W'(1));

    always_comb begin
        state_d = state_q;
        user_d  = user_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        wdt_d   = wdt_q;
        idx_d   = idx_q;
        e01_d   = e01_q;
        ncb_d   = ncb_q;
        qm_d    = qm_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
        euser_d = euser_q;
        adv     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    code_d  = ERR_NONE;
                    euser_d = 4'd0;
                    if (i_num_users == 4'd0) begin
                        done_d = 1'b1;
                    end else if ({1'b0, i_num_users} > NU5) begin
                        err_d  = 1'b1;
                        code_d = ERR_CNT;
                    end else begin
                        cnt_d   = i_num_users;
                        user_d  = 4'd0;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                idx_d = user_q;
                e01_d = rd_e01;
                ncb_d = rd_ncb;
                qm_d  = rd_qm;
                wdt_d = '0;
                if (rd_e01 == '0) adv = 1'b1;
                else              state_d = S_REQ;
            end
            S_REQ: begin
                if (eng.i_combine_done) begin
                    gap_d   = 4'd0;
                    state_d = S_GAP;
                end else if (wdt_hit) begin
                    err_d   = 1'b1;
                    code_d  = ERR_WDT;
                    euser_d = user_q;
                    state_d = S_IDLE;
                end else begin
                    wdt_d = wdt_q + WDT_W'(1);
                end
            end
            S_GAP: begin
                if (gap_q == GAP_M1) adv = 1'b1;
                else                 gap_d = gap_q + 4'd1;
            end
            default: state_d = S_IDLE;
        endcase

        if (adv) begin
            if (({1'b0, user_q} + 5'd1) < {1'b0, cnt_q}) begin
                user_d  = user_q + 4'd1;
                state_d = S_LOAD;
            end else begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
        end

        if (i_abort) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            err_d   = 1'b0;
            code_d  = code_q;
            euser_d = euser_q;
        end
    end

    always_ff @(posedge i_core_clk) begin
        if (i_rx_rst) begin
            state_q <= S_IDLE;
            user_q  <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            wdt_q   <= '0;
            idx_q   <= '0;
            e01_q   <= '0;
            ncb_q   <= '0;
            qm_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
            euser_q <= '0;
        end else begin
            state_q <= state_d;
            user_q  <= user_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            wdt_q   <= wdt_d;
            idx_q   <= idx_d;
            e01_q   <= e01_d;
            ncb_q   <= ncb_d;
            qm_q    <= qm_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
            euser_q <= euser_d;
        end
    end

    assign eng.o_Combine_process_request  = (state_q == S_REQ);
    assign eng.o_Combine_user_index       = idx_q;
    assign eng.o_Current_Combine_E01_Size = e01_q;
    assign eng.o_Current_Combine_Ncb_Size = ncb_q;
    assign eng.o_users_qm                 = qm_q;

    assign o_busy     = (state_q != S_IDLE);
    assign o_done     = done_q;
    assign o_err      = err_q;
    assign o_err_code = code_q;
    assign o_err_user = euser_q;

endmodule

// File: tb/tb_rdm_user_scheduler.sv
// Directed bench for rdm_user_scheduler: slot sequencing, skip,
// watchdog, bad counts, abort, write race and reset.
module tb_rdm_user_scheduler;

    localparam int NU    = 8;
    localparam int E01_W = 14;
    localparam int NCB_W = 16;
    localparam int QM_W  = 4;
    localparam int GAP   = 2;
    localparam int WDT_W = 20;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cfg_we = 1'b0;
    logic [3:0]       cfg_user = '0;
    logic [E01_W-1:0] cfg_e01 = '0;
    logic [NCB_W-1:0] cfg_ncb = '0;
    logic [QM_W-1:0]  cfg_qm = '0;
    logic [3:0]       num_users = '0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [WDT_W-1:0] wdt_limit = '0;
    logic             o_busy, o_done, o_err;
    logic [1:0]       o_err_code;
    logic [3:0]       o_err_user;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int rise_cnt = 0;
    logic req_prev = 1'b0;
    int d0, e0, r0;

    rdm_user_scheduler_if #(
        .E01_W (E01_W), .NCB_W (NCB_W), .QM_W (QM_W)
    ) eng_if ();

    rdm_user_scheduler #(
        .NUM_USERS (NU), .E01_W (E01_W), .NCB_W (NCB_W),
        .QM_W (QM_W), .GAP_CYCLES (GAP), .WDT_W (WDT_W)
    ) dut (
        .i_core_clk  (clk),
        .i_rx_rst    (rst),
        .i_cfg_we    (cfg_we),
        .i_cfg_user  (cfg_user),
        .i_cfg_e01   (cfg_e01),
        .i_cfg_ncb   (cfg_ncb),
        .i_cfg_qm    (cfg_qm),
        .i_num_users (num_users),
        .i_start     (start),
        .i_abort     (abort),
        .i_wdt_limit (wdt_limit),
        .eng         (eng_if.master),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err),
        .o_err_code  (o_err_code),
        .o_err_user  (o_err_user)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (o_done) done_cnt++;
        if (o_err) err_cnt++;
        if (eng_if.o_Combine_process_request && !req_prev) rise_cnt++;
        req_prev = eng_if.o_Combine_process_request;
    endtask

    task automatic cfg(input logic [3:0] u, input logic [E01_W-1:0] e,
                       input logic [NCB_W-1:0] n, input logic [QM_W-1:0] q);
        cfg_we = 1'b1; cfg_user = u; cfg_e01 = e; cfg_ncb = n; cfg_qm = q;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic go(input logic [3:0] n);
        num_users = n; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Entered in a REQ cycle; completes the user 10 cycles after this call.
    task automatic serve(input int idx, input int e, input int n,
                         input int q, input bit last);
        chk("req_high", eng_if.o_Combine_process_request, 1);
        chk("idx", eng_if.o_Combine_user_index, idx);
        chk("e01", eng_if.o_Current_Combine_E01_Size, e);
        chk("ncb", eng_if.o_Current_Combine_Ncb_Size, n);
        chk("qm", eng_if.o_users_qm, q);
        repeat (10) tick();
        chk("req_hold", eng_if.o_Combine_process_request, 1);
        eng_if.i_combine_done = 1'b1;
        tick();
        eng_if.i_combine_done = 1'b0;
        chk("req_drop", eng_if.o_Combine_process_request, 0);
        repeat (GAP - 1) tick();
        chk("gap_busy", o_busy, 1);
        chk("gap_req", eng_if.o_Combine_process_request, 0);
        tick();
        if (last) begin
            chk("last_done", o_done, 1);
            chk("last_busy", o_busy, 0);
        end else begin
            chk("load_req", eng_if.o_Combine_process_request, 0);
            chk("load_busy", o_busy, 1);
            tick();
        end
    endtask

    initial begin
        eng_if.i_combine_done = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_req", eng_if.o_Combine_process_request, 0);
        chk("rst_idx", eng_if.o_Combine_user_index, 0);
        chk("rst_e01", eng_if.o_Current_Combine_E01_Size, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_err", o_err, 0);
        chk("rst_code", o_err_code, 0);

        // three users
        cfg(0, 129, 110, 2);
        cfg(1, 64, 80, 4);
        cfg(2, 200, 300, 6);
        d0 = done_cnt; r0 = rise_cnt;
        go(3);
        chk("t1_load_busy", o_busy, 1);
        chk("t1_load_req", eng_if.o_Combine_process_request, 0);
        tick();
        serve(0, 129, 110, 2, 0);
        serve(1, 64, 80, 4, 0);
        serve(2, 200, 300, 6, 1);
        chk("t1_rises", rise_cnt - r0, 3);
        chk("t1_dones", done_cnt - d0, 1);
        tick();
        chk("t1_done_pulse", o_done, 0);
        chk("t1_hold_idx", eng_if.o_Combine_user_index, 2);
        chk("t1_hold_ncb", eng_if.o_Current_Combine_Ncb_Size, 300);

        // skipped user
        cfg(1, 0, 5, 1);
        r0 = rise_cnt;
        go(3);
        tick();
        serve(0, 129, 110, 2, 0);
        chk("t2_skip_req", eng_if.o_Combine_process_request, 0);
        chk("t2_skip_idx", eng_if.o_Combine_user_index, 1);
        chk("t2_skip_e01", eng_if.o_Current_Combine_E01_Size, 0);
        tick();
        serve(2, 200, 300, 6, 1);
        chk("t2_rises", rise_cnt - r0, 2);

        // watchdog
        wdt_limit = 50;
        d0 = done_cnt; e0 = err_cnt;
        go(1);
        tick();
        chk("t3_req", eng_if.o_Combine_process_request, 1);
        repeat (49) tick();
        chk("t3_req49", eng_if.o_Combine_process_request, 1);
        chk("t3_noerr49", err_cnt - e0, 0);
        tick();
        chk("t3_err", o_err, 1);
        chk("t3_code", o_err_code, 1);
        chk("t3_user", o_err_user, 0);
        chk("t3_req_low", eng_if.o_Combine_process_request, 0);
        chk("t3_busy", o_busy, 0);
        tick();
        chk("t3_err_pulse", o_err, 0);
        chk("t3_code_hold", o_err_code, 1);
        chk("t3_nodone", done_cnt - d0, 0);
        wdt_limit = 0;

        // bad user counts
        r0 = rise_cnt;
        go(0);
        chk("t4_zero_done", o_done, 1);
        chk("t4_zero_err", o_err, 0);
        chk("t4_zero_busy", o_busy, 0);
        chk("t4_zero_code", o_err_code, 0);
        tick();
        go(9);
        chk("t4_nine_err", o_err, 1);
        chk("t4_nine_code", o_err_code, 2);
        chk("t4_nine_busy", o_busy, 0);
        chk("t4_nine_done", o_done, 0);
        repeat (5) tick();
        chk("t4_norise", rise_cnt - r0, 0);

        // abort racing combine_done
        d0 = done_cnt; e0 = err_cnt; r0 = rise_cnt;
        go(3);
        tick();
        chk("t5_req", eng_if.o_Combine_process_request, 1);
        repeat (10) tick();
        eng_if.i_combine_done = 1'b1;
        abort = 1'b1;
        tick();
        eng_if.i_combine_done = 1'b0;
        abort = 1'b0;
        chk("t5_busy", o_busy, 0);
        chk("t5_req_low", eng_if.o_Combine_process_request, 0);
        repeat (30) tick();
        chk("t5_rises", rise_cnt - r0, 1);
        chk("t5_nodone", done_cnt - d0, 0);
        chk("t5_noerr", err_cnt - e0, 0);
        chk("t5_code", o_err_code, 0);

        // config writes during user 0's REQ
        go(2);
        tick();
        cfg(1, 77, 99, 3);
        cfg(0, 5, 6, 7);
        serve(0, 129, 110, 2, 0);
        serve(1, 77, 99, 3, 1);

        // reset mid-REQ clears outputs and table
        go(1);
        tick();
        chk("t7_e01", eng_if.o_Current_Combine_E01_Size, 5);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t7_req", eng_if.o_Combine_process_request, 0);
        chk("t7_busy", o_busy, 0);
        chk("t7_e01_0", eng_if.o_Current_Combine_E01_Size, 0);
        chk("t7_qm_0", eng_if.o_users_qm, 0);
        r0 = rise_cnt;
        go(1);
        tick();
        chk("t7_skip_done", o_done, 1);
        chk("t7_skip_busy", o_busy, 0);
        chk("t7_tbl_ncb", eng_if.o_Current_Combine_Ncb_Size, 0);
        chk("t7_norise", rise_cnt - r0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
